// File: rtl/bus_control_pkg.sv
// Shared state type, bus constants and packed-parameter helpers for the
// parametrised 68000 bus controller.
package bus_control_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_EXTW = 3'd2,
        ST_ACK  = 3'd3,
        ST_ERR  = 3'd4
    } bus_state_e;

    // Function code presented by the CPU during an interrupt-acknowledge cycle.
    localparam logic [2:0] FC_IACK = 3'b111;

    // Upper bound on region count; region indices always fit in IDX_W bits.
    localparam int MAX_REGIONS = 8;
    localparam int IDX_W       = 3;
    // Packed per-region parameters are widened to this before field extraction.
    localparam int FIELD_VEC_W = 256;

    // Extract field idx of the given width from a packed per-region vector.
    function automatic logic [31:0] field_at(input logic [FIELD_VEC_W-1:0] vec,
                                             input int idx,
                                             input int width);
        logic [31:0] low_bits;
        logic [31:0] mask;
        low_bits = 32'(vec >> (idx * width));
        if (width >= 32) begin
            mask = 32'hFFFF_FFFF;
        end else begin
            mask = (32'd1 << width) - 32'd1;
        end
        return low_bits & mask;
    endfunction

    // Read one per-region flag bit.
    function automatic logic flag_at(input logic [MAX_REGIONS-1:0] vec,
                                     input logic [IDX_W-1:0] idx);
        return vec[idx];
    endfunction

    // Highest pending request level (bit6 = level 7), 0 when none pending.
    function automatic logic [2:0] int_priority(input logic [6:0] req);
        logic [2:0] level;
        level = 3'd0;
        for (int i = 0; i < 7; i++) begin
            if (req[i]) begin
                level = 3'(i + 1);
            end else begin
                level = level;
            end
        end
        return level;
    endfunction

endpackage

// File: rtl/bus_region_decoder.sv
// Combinational address decoder: finds the region whose tag matches the top
// address bits (lowest index wins), applies the boot overlay and reports the
// attributes of the selected region.
module bus_region_decoder
    import bus_control_pkg::*;
#(
    parameter int NUM_REGIONS = 4,
    parameter int ADDR_WIDTH = 24,
    parameter int TAG_BITS = 4,
    parameter int WAIT_WIDTH = 3,
    parameter logic [NUM_REGIONS*TAG_BITS-1:0] REGION_TAGS = {4'hF, 4'h1, 4'h0, 4'h0},
    parameter logic [NUM_REGIONS*WAIT_WIDTH-1:0] REGION_WAITS = '0,
    parameter logic [NUM_REGIONS-1:0] REGION_RO = 4'b1000,
    parameter logic [NUM_REGIONS-1:0] REGION_EXT = 4'b0000,
    parameter int BOOT_REGION = 3
) (
    input  logic [ADDR_WIDTH-1:0]  addr,
    input  logic                   wr,
    input  logic                   bootstrapped,
    output logic [NUM_REGIONS-1:0] region_onehot,
    output logic                   hit,
    output logic                   ro_violation,
    output logic                   is_ext,
    output logic [WAIT_WIDTH-1:0]  wait_count
);

    localparam logic [FIELD_VEC_W-1:0] TAGS_VEC  = FIELD_VEC_W'(REGION_TAGS);
    localparam logic [FIELD_VEC_W-1:0] WAITS_VEC = FIELD_VEC_W'(REGION_WAITS);
    localparam logic [MAX_REGIONS-1:0] RO_VEC    = MAX_REGIONS'(REGION_RO);
    localparam logic [MAX_REGIONS-1:0] EXT_VEC   = MAX_REGIONS'(REGION_EXT);
    localparam logic [IDX_W-1:0]       BOOT_IDX  = IDX_W'(BOOT_REGION);

    logic [TAG_BITS-1:0] addr_tag_s;
    logic [IDX_W-1:0]    raw_idx_s;
    logic [IDX_W-1:0]    sel_idx_s;
    logic                hit_s;
    logic                unused_addr_s;

    assign addr_tag_s    = addr[ADDR_WIDTH-1 -: TAG_BITS];
    assign unused_addr_s = ^addr[ADDR_WIDTH-TAG_BITS-1:0];

    // Tag match; scanning downwards leaves the lowest matching region index.
    always_comb begin
        hit_s     = 1'b0;
        raw_idx_s = '0;
        for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
            if (addr_tag_s == TAG_BITS'(field_at(TAGS_VEC, i, TAG_BITS))) begin
                hit_s     = 1'b1;
                raw_idx_s = IDX_W'(i);
            end else begin
                hit_s     = hit_s;
                raw_idx_s = raw_idx_s;
            end
        end
    end

    // Boot overlay: reads of region 0 go to the boot region until bootstrapped.
    always_comb begin
        if (hit_s && !wr && !bootstrapped && (raw_idx_s == '0)) begin
            sel_idx_s = BOOT_IDX;
        end else begin
            sel_idx_s = raw_idx_s;
        end
    end

    // Attributes of the selected region.
    always_comb begin
        region_onehot = '0;
        for (int i = 0; i < NUM_REGIONS; i++) begin
            region_onehot[i] = hit_s && (sel_idx_s == IDX_W'(i));
        end
        hit          = hit_s;
        ro_violation = hit_s & wr & flag_at(RO_VEC, sel_idx_s);
        is_ext       = flag_at(EXT_VEC, sel_idx_s);
        wait_count   = WAIT_WIDTH'(field_at(WAITS_VEC, int'(sel_idx_s), WAIT_WIDTH));
    end

endmodule

// File: rtl/bus_control_param.sv
// Parametrised 68000 bus controller: region chip selects with wait states,
// external-ack regions with timeout, boot overlay and a registered interrupt
// priority encoder with autovector acknowledge. All state moves on the
// falling CPU clock edge.
module bus_control_param
    import bus_control_pkg::*;
#(
    parameter int NUM_REGIONS = 4,
    parameter int ADDR_WIDTH = 24,
    parameter int TAG_BITS = 4,
    parameter int WAIT_WIDTH = 3,
    parameter logic [NUM_REGIONS*TAG_BITS-1:0] REGION_TAGS = {4'hF, 4'h1, 4'h0, 4'h0},
    parameter logic [NUM_REGIONS*WAIT_WIDTH-1:0] REGION_WAITS = '0,
    parameter logic [NUM_REGIONS-1:0] REGION_RO = 4'b1000,
    parameter logic [NUM_REGIONS-1:0] REGION_EXT = 4'b0000,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int BOOT_REGION = 3
) (
    input  logic                   CPUCLK_IN,
    input  logic                   RUN_IN,
    input  logic                   AS_IN,
    input  logic                   WR_IN,
    input  logic                   UDS_IN,
    input  logic                   LDS_IN,
    input  logic [2:0]             STATUS_CODE_IN,
    input  logic [ADDR_WIDTH-1:0]  ADDR_IN,
    input  logic                   EXT_ACK_IN,
    input  logic [6:0]             INT_REQ_IN,
    output logic [NUM_REGIONS-1:0] CS_UPPER,
    output logic [NUM_REGIONS-1:0] CS_LOWER,
    output logic                   OUTPUT_ENABLE,
    output logic                   DATA_ACK,
    output logic                   BUS_ERROR,
    output logic                   INT_AUTOVEC_ACK,
    output logic [2:0]             INT_LEVEL,
    output logic                   BOOTSTRAPPED
);

    // Counter serves both the wait-state count and the external-ack timeout.
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES);
    localparam int CNT_W = (WAIT_WIDTH > TO_W) ? WAIT_WIDTH : TO_W;

    bus_state_e state_r, state_n;
    logic [CNT_W-1:0]       cnt_r, cnt_n;
    logic [NUM_REGIONS-1:0] cs_upper_r, cs_upper_n;
    logic [NUM_REGIONS-1:0] cs_lower_r, cs_lower_n;
    logic oe_r, oe_n;
    logic dack_r, dack_n;
    logic berr_r, berr_n;
    logic vpa_r, vpa_n;
    logic boot_r, boot_n;
    logic iack_r, iack_n;
    logic [2:0] int_level_r;

    logic                   stb_s;
    logic [NUM_REGIONS-1:0] region_s;
    logic                   hit_s;
    logic                   ro_s;
    logic                   ext_s;
    logic [WAIT_WIDTH-1:0]  wait_s;

    assign stb_s = AS_IN & (UDS_IN | LDS_IN);

    bus_region_decoder #(
        .NUM_REGIONS (NUM_REGIONS),
        .ADDR_WIDTH  (ADDR_WIDTH),
        .TAG_BITS    (TAG_BITS),
        .WAIT_WIDTH  (WAIT_WIDTH),
        .REGION_TAGS (REGION_TAGS),
        .REGION_WAITS(REGION_WAITS),
        .REGION_RO   (REGION_RO),
        .REGION_EXT  (REGION_EXT),
        .BOOT_REGION (BOOT_REGION)
    ) u_decoder (
        .addr         (ADDR_IN),
        .wr           (WR_IN),
        .bootstrapped (boot_r),
        .region_onehot(region_s),
        .hit          (hit_s),
        .ro_violation (ro_s),
        .is_ext       (ext_s),
        .wait_count   (wait_s)
    );

    // Next state and next outputs of the bus cycle; a dropped strobe always ends the cycle.
    always_comb begin
        state_n    = state_r;
        cnt_n      = cnt_r;
        cs_upper_n = cs_upper_r;
        cs_lower_n = cs_lower_r;
        oe_n       = oe_r;
        dack_n     = dack_r;
        berr_n     = berr_r;
        vpa_n      = vpa_r;
        boot_n     = boot_r;
        iack_n     = iack_r;
        if (!stb_s) begin
            state_n    = ST_IDLE;
            cnt_n      = '0;
            cs_upper_n = '0;
            cs_lower_n = '0;
            oe_n       = 1'b0;
            dack_n     = 1'b0;
            berr_n     = 1'b0;
            vpa_n      = 1'b0;
            iack_n     = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (STATUS_CODE_IN == FC_IACK) begin
                        iack_n = 1'b1;
                        if ((ADDR_IN[3:1] == int_level_r) && (int_level_r != 3'd0) && !WR_IN) begin
                            state_n = ST_ACK;
                            vpa_n   = 1'b1;
                        end else begin
                            state_n = ST_ERR;
                            berr_n  = 1'b1;
                        end
                    end else if (!hit_s || ro_s) begin
                        iack_n  = 1'b0;
                        state_n = ST_ERR;
                        berr_n  = 1'b1;
                    end else begin
                        iack_n     = 1'b0;
                        cs_upper_n = region_s & {NUM_REGIONS{UDS_IN}};
                        cs_lower_n = region_s & {NUM_REGIONS{LDS_IN}};
                        oe_n       = ~WR_IN;
                        // Only a write reaches region 0 itself while the overlay is active.
                        if (WR_IN && region_s[0]) begin
                            boot_n = 1'b1;
                        end else begin
                            boot_n = boot_r;
                        end
                        if (ext_s) begin
                            state_n = ST_EXTW;
                            cnt_n   = CNT_W'(TIMEOUT_CYCLES - 1);
                        end else begin
                            state_n = ST_WAIT;
                            cnt_n   = CNT_W'(wait_s);
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt_r == '0) begin
                        state_n = ST_ACK;
                        dack_n  = 1'b1;
                    end else begin
                        cnt_n = cnt_r - CNT_W'(1);
                    end
                end
                ST_EXTW: begin
                    if (EXT_ACK_IN) begin
                        state_n = ST_ACK;
                        dack_n  = 1'b1;
                    end else if (cnt_r == '0) begin
                        state_n    = ST_ERR;
                        berr_n     = 1'b1;
                        cs_upper_n = '0;
                        cs_lower_n = '0;
                        oe_n       = 1'b0;
                    end else begin
                        cnt_n = cnt_r - CNT_W'(1);
                    end
                end
                ST_ACK: begin
                    state_n = ST_ACK;
                end
                ST_ERR: begin
                    state_n = ST_ERR;
                end
                default: begin
                    state_n    = ST_IDLE;
                    cnt_n      = '0;
                    cs_upper_n = '0;
                    cs_lower_n = '0;
                    oe_n       = 1'b0;
                    dack_n     = 1'b0;
                    berr_n     = 1'b0;
                    vpa_n      = 1'b0;
                    iack_n     = 1'b0;
                end
            endcase
        end
    end

    // Bus-cycle state and registered bus outputs; RUN_IN low clears everything.
    always_ff @(negedge CPUCLK_IN) begin
        if (!RUN_IN) begin
            state_r    <= ST_IDLE;
            cnt_r      <= '0;
            cs_upper_r <= '0;
            cs_lower_r <= '0;
            oe_r       <= 1'b0;
            dack_r     <= 1'b0;
            berr_r     <= 1'b0;
            vpa_r      <= 1'b0;
            boot_r     <= 1'b0;
            iack_r     <= 1'b0;
        end else begin
            state_r    <= state_n;
            cnt_r      <= cnt_n;
            cs_upper_r <= cs_upper_n;
            cs_lower_r <= cs_lower_n;
            oe_r       <= oe_n;
            dack_r     <= dack_n;
            berr_r     <= berr_n;
            vpa_r      <= vpa_n;
            boot_r     <= boot_n;
            iack_r     <= iack_n;
        end
    end

    // Interrupt level tracks the requests, but holds still through an acknowledge cycle.
    always_ff @(negedge CPUCLK_IN) begin
        if (!RUN_IN) begin
            int_level_r <= 3'd0;
        end else if (iack_r && (state_r != ST_IDLE)) begin
            int_level_r <= int_level_r;
        end else begin
            int_level_r <= int_priority(INT_REQ_IN);
        end
    end

    assign CS_UPPER        = cs_upper_r;
    assign CS_LOWER        = cs_lower_r;
    assign OUTPUT_ENABLE   = oe_r;
    assign DATA_ACK        = dack_r;
    assign BUS_ERROR       = berr_r;
    assign INT_AUTOVEC_ACK = vpa_r;
    assign INT_LEVEL       = int_level_r;
    assign BOOTSTRAPPED    = boot_r;

endmodule

// File: tb/tb_bus_control_param.sv
// Directed bench for bus_control_param with a transaction-level reference
// model and hand-computed latency/select expectations.
module tb_bus_control_param;

    localparam int NR      = 5;
    localparam int TIMEOUT = 64;
    localparam int K_MEM   = 0;
    localparam int K_IACK  = 1;
    localparam int K_ERR   = 2;

    logic clk = 1'b1;
    logic run_in, as_in, wr_in, uds_in, lds_in, ext_ack_in;
    logic [2:0]  fc_in;
    logic [23:0] addr_in;
    logic [6:0]  int_req_in;
    logic [NR-1:0] cs_upper, cs_lower;
    logic oe, dack, berr, vpa, bootstrapped;
    logic [2:0] int_level;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;
    int lat;

    // Region map used by the model: r0 tag 0, r1 tag 2 (5 waits), r2 tag 1 external,
    // r3 tag F read-only boot region, r4 tag 2 (shadowed by r1).
    int tag_tab[NR]  = '{0, 2, 1, 15, 2};
    int wait_tab[NR] = '{2, 5, 0, 1, 7};
    bit ro_tab[NR]   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    bit ext_tab[NR]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    // Model state
    bit m_boot, m_active, m_write, m_uds, m_lds, m_ext, m_iack_ok;
    int m_level, m_kind, m_region, m_age, m_wait, m_done;
    logic [NR-1:0] exp_cs_upper, exp_cs_lower;
    logic exp_oe, exp_dack, exp_berr, exp_vpa, exp_boot;
    logic [2:0] exp_level;

    always #5 clk = ~clk;

    bus_control_param #(
        .NUM_REGIONS   (5),
        .ADDR_WIDTH    (24),
        .TAG_BITS      (4),
        .WAIT_WIDTH    (3),
        .REGION_TAGS   (20'h2F120),
        .REGION_WAITS  (15'b111_001_000_101_010),
        .REGION_RO     (5'b01000),
        .REGION_EXT    (5'b00100),
        .TIMEOUT_CYCLES(64),
        .BOOT_REGION   (3)
    ) dut (
        .CPUCLK_IN      (clk),
        .RUN_IN         (run_in),
        .AS_IN          (as_in),
        .WR_IN          (wr_in),
        .UDS_IN         (uds_in),
        .LDS_IN         (lds_in),
        .STATUS_CODE_IN (fc_in),
        .ADDR_IN        (addr_in),
        .EXT_ACK_IN     (ext_ack_in),
        .INT_REQ_IN     (int_req_in),
        .CS_UPPER       (cs_upper),
        .CS_LOWER       (cs_lower),
        .OUTPUT_ENABLE  (oe),
        .DATA_ACK       (dack),
        .BUS_ERROR      (berr),
        .INT_AUTOVEC_ACK(vpa),
        .INT_LEVEL      (int_level),
        .BOOTSTRAPPED   (bootstrapped)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, expv);
        end
    endtask

    function automatic int prio(input logic [6:0] req);
        int lvl;
        lvl = 0;
        for (int i = 0; i < 7; i++) begin
            if (req[i]) lvl = i + 1;
        end
        return lvl;
    endfunction

    // Advance the model by one falling edge using the inputs seen at that edge.
    task automatic model_edge();
        int old_level;
        int r;
        bit stb;
        if (!run_in) begin
            m_boot   = 1'b0;
            m_level  = 0;
            m_active = 1'b0;
        end else begin
            old_level = m_level;
            if (!(m_active && m_kind == K_IACK)) m_level = prio(int_req_in);
            stb = as_in && (uds_in || lds_in);
            if (!stb) begin
                m_active = 1'b0;
            end else if (m_active) begin
                m_age++;
                if (m_kind == K_MEM && m_done == 0) begin
                    if (m_ext) begin
                        if (ext_ack_in) m_done = 1;
                        else if (m_age >= TIMEOUT) m_done = 2;
                    end else if (m_age >= m_wait + 1) begin
                        m_done = 1;
                    end
                end
            end else begin
                m_active = 1'b1;
                m_age    = 0;
                m_done   = 0;
                if (fc_in == 3'b111) begin
                    m_kind    = K_IACK;
                    m_iack_ok = (int'(addr_in[3:1]) == old_level) && (old_level != 0) && !wr_in;
                end else begin
                    r = -1;
                    for (int i = 0; i < NR; i++) begin
                        if (r < 0 && tag_tab[i] == int'(addr_in >> 20)) r = i;
                    end
                    if (r < 0) begin
                        m_kind = K_ERR;
                    end else begin
                        if (r == 0 && !wr_in && !m_boot) r = 3;
                        if (wr_in && ro_tab[r]) begin
                            m_kind = K_ERR;
                        end else begin
                            m_kind   = K_MEM;
                            m_region = r;
                            m_write  = wr_in;
                            m_uds    = uds_in;
                            m_lds    = lds_in;
                            m_wait   = wait_tab[r];
                            m_ext    = ext_tab[r];
                            if (wr_in && r == 0) m_boot = 1'b1;
                        end
                    end
                end
            end
        end
        exp_cs_upper = '0;
        exp_cs_lower = '0;
        exp_oe       = 1'b0;
        if (m_active && m_kind == K_MEM && m_done != 2) begin
            if (m_uds) exp_cs_upper[m_region] = 1'b1;
            if (m_lds) exp_cs_lower[m_region] = 1'b1;
            exp_oe = !m_write;
        end
        exp_dack  = m_active && m_kind == K_MEM && m_done == 1;
        exp_berr  = m_active && (m_kind == K_ERR || (m_kind == K_MEM && m_done == 2) ||
                                 (m_kind == K_IACK && !m_iack_ok));
        exp_vpa   = m_active && m_kind == K_IACK && m_iack_ok;
        exp_level = 3'(m_level);
        exp_boot  = m_boot;
    endtask

    // Compare every DUT output against the model on the rising edge.
    always @(posedge clk) begin
        if (cmp_en) begin
            check("cs_upper", 32'(cs_upper), 32'(exp_cs_upper));
            check("cs_lower", 32'(cs_lower), 32'(exp_cs_lower));
            check("oe", 32'(oe), 32'(exp_oe));
            check("dack", 32'(dack), 32'(exp_dack));
            check("berr", 32'(berr), 32'(exp_berr));
            check("vpa", 32'(vpa), 32'(exp_vpa));
            check("int_level", 32'(int_level), 32'(exp_level));
            check("bootstrapped", 32'(bootstrapped), 32'(exp_boot));
        end
    end

    task automatic cyc();
        @(negedge clk);
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        as_in = 1'b0; wr_in = 1'b0; uds_in = 1'b0; lds_in = 1'b0;
        fc_in = 3'b101; addr_in = 24'h000000; ext_ack_in = 1'b0;
    endtask

    task automatic begin_cycle(input logic [23:0] a, input logic w, input logic u,
                               input logic l, input logic [2:0] fc);
        addr_in = a; wr_in = w; uds_in = u; lds_in = l; fc_in = fc; as_in = 1'b1;
        cyc();
    endtask

    task automatic end_cycle();
        set_idle();
        cyc();
    endtask

    // sel: 0 = DATA_ACK, 1 = BUS_ERROR, 2 = INT_AUTOVEC_ACK; edges = -1 on timeout.
    task automatic run_until(input int sel, input int max_edges, output int edges);
        edges = -1;
        for (int k = 1; k <= max_edges && edges < 0; k++) begin
            cyc();
            if ((sel == 0 && dack) || (sel == 1 && berr) || (sel == 2 && vpa)) edges = k;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        run_in = 1'b0;
        int_req_in = 7'b0000000;
        set_idle();
        cyc();
        cmp_en = 1'b1;
        cyc();
        check("rst_boot", 32'(bootstrapped), 32'd0);
        check("rst_level", 32'(int_level), 32'd0);
        check("rst_cs", 32'(cs_upper), 32'd0);
        run_in = 1'b1;
        cyc();

        // Boot overlay read goes to region 3 (1 wait state)
        begin_cycle(24'h000010, 1'b0, 1'b1, 1'b1, 3'b110);
        check("boot_read_cs", 32'(cs_upper), 32'h08);
        check("boot_read_oe", 32'(oe), 32'd1);
        run_until(0, 20, lat);
        check("boot_read_lat", 32'(lat), 32'd2);
        check("boot_read_boot", 32'(bootstrapped), 32'd0);
        end_cycle();

        // Write to region 0 releases the overlay
        begin_cycle(24'h000010, 1'b1, 1'b1, 1'b1, 3'b101);
        check("boot_write_csu", 32'(cs_upper), 32'h01);
        check("boot_write_csl", 32'(cs_lower), 32'h01);
        check("boot_write_oe", 32'(oe), 32'd0);
        check("boot_write_boot", 32'(bootstrapped), 32'd1);
        run_until(0, 20, lat);
        check("boot_write_lat", 32'(lat), 32'd3);
        end_cycle();

        // Same address now reads region 0, upper byte only
        begin_cycle(24'h000010, 1'b0, 1'b1, 1'b0, 3'b101);
        check("r0_read_csu", 32'(cs_upper), 32'h01);
        check("r0_read_csl", 32'(cs_lower), 32'h00);
        run_until(0, 20, lat);
        check("r0_read_lat", 32'(lat), 32'd3);
        end_cycle();

        // Overlapping tag 2: region 1 wins, 5 wait states
        begin_cycle(24'h200000, 1'b0, 1'b0, 1'b1, 3'b101);
        check("w5_csl", 32'(cs_lower), 32'h02);
        run_until(0, 20, lat);
        check("w5_lat", 32'(lat), 32'd6);
        end_cycle();

        // AS dropped at edge 3 aborts with no acknowledge
        begin_cycle(24'h200000, 1'b0, 1'b1, 1'b1, 3'b101);
        cyc();
        cyc();
        as_in = 1'b0;
        cyc();
        check("abort_cs", 32'(cs_upper), 32'h00);
        check("abort_dack", 32'(dack), 32'd0);
        set_idle();
        repeat (6) cyc();

        // Write to read-only region
        begin_cycle(24'hF00000, 1'b1, 1'b1, 1'b1, 3'b101);
        check("ro_berr", 32'(berr), 32'd1);
        check("ro_cs", 32'(cs_upper), 32'h00);
        end_cycle();

        // Unmapped address
        begin_cycle(24'h500000, 1'b0, 1'b1, 1'b1, 3'b101);
        check("unmapped_berr", 32'(berr), 32'd1);
        end_cycle();

        // External region timeout
        begin_cycle(24'h100000, 1'b0, 1'b1, 1'b1, 3'b101);
        check("ext_cs", 32'(cs_upper), 32'h04);
        run_until(1, 100, lat);
        check("ext_timeout_lat", 32'(lat), 32'd64);
        check("ext_timeout_cs", 32'(cs_upper), 32'h00);
        end_cycle();

        // External acknowledge raised after edge 10
        begin_cycle(24'h100000, 1'b0, 1'b1, 1'b1, 3'b101);
        repeat (10) cyc();
        check("ext_pre_dack", 32'(dack), 32'd0);
        ext_ack_in = 1'b1;
        cyc();
        check("ext_ack_dack", 32'(dack), 32'd1);
        ext_ack_in = 1'b0;
        cyc();
        check("ext_ack_hold", 32'(dack), 32'd1);
        end_cycle();

        // Interrupt encoder and autovector acknowledge
        int_req_in = 7'b0000101;
        cyc();
        check("int_level_3", 32'(int_level), 32'd3);
        begin_cycle(24'hFFFFF6, 1'b0, 1'b1, 1'b1, 3'b111);
        check("iack_vpa", 32'(vpa), 32'd1);
        check("iack_cs", 32'(cs_upper), 32'h00);
        int_req_in = 7'b1000000;
        cyc();
        check("iack_frozen", 32'(int_level), 32'd3);
        end_cycle();
        check("iack_end_frozen", 32'(int_level), 32'd3);
        cyc();
        check("int_level_7", 32'(int_level), 32'd7);
        int_req_in = 7'b0000101;
        cyc();
        begin_cycle(24'hFFFFF2, 1'b0, 1'b1, 1'b1, 3'b111);
        check("iack_bad_berr", 32'(berr), 32'd1);
        check("iack_bad_vpa", 32'(vpa), 32'd0);
        end_cycle();

        // Reset in the middle of a wait-state cycle
        begin_cycle(24'h200000, 1'b0, 1'b1, 1'b1, 3'b101);
        cyc();
        cyc();
        run_in = 1'b0;
        cyc();
        check("midrst_cs", 32'(cs_upper), 32'h00);
        check("midrst_oe", 32'(oe), 32'd0);
        check("midrst_dack", 32'(dack), 32'd0);
        check("midrst_boot", 32'(bootstrapped), 32'd0);
        check("midrst_level", 32'(int_level), 32'd0);
        set_idle();
        run_in = 1'b1;
        repeat (3) cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
